uart_rx_sim: RTL and testbench
==============================

Name: uart_rx_sim

Overview:
- Simulation UART receiver: deserialises an 8N1 serial line into an 8-entry receive FIFO.
- Exposes the FIFO to the core through the same slave bus (req/gnt/rvalid) as the existing UART transmit model, so the core can read host-injected characters.
- Sits beside uart_sim in the verilator top at a separate decode window; the top gates req with its own address decode.

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries; must be a power of 2.
- DEFAULT_DIV, 16, reset value of BAUD_DIV (clocks per bit).
- DIV_W, 16, width of the divider register and bit counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- rx_i  in  1  serial input; idle high; asynchronous to clk.
- req  in  1  bus request, already address-qualified by the top.
- addr  in  32  byte address; only addr[3:2] is decoded.
- we  in  1  1 = write.
- be  in  4  byte enables.
- wdata  in  32  write data.
- rdata  out  32  read data; valid only while rvalid=1, otherwise 0.
- gnt  out  1  grant; combinational, gnt = req.
- rvalid  out  1  response valid, exactly one cycle after each granted req.
- err  out  1  error response, qualified by rvalid.
- irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Clock and reset: one clock. resetn is synchronous and active-low.
- Reset (any cycle, including mid-frame or mid-transaction):
  - FSM goes to IDLE; FIFO emptied; overrun and frame_err cleared.
  - BAUD_DIV = DEFAULT_DIV; rvalid/err/irq = 0; rdata = 0.
  - Synchroniser flops = 1.
- Input sync: rx_i passes through 2 flops giving rx_s; all sampling uses rx_s.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: when rx_s = 0, go to START with cnt = BAUD_DIV/2 - 1.
  - START: decrement cnt; at cnt = 0 sample rx_s.
    - 0: go to DATA with cnt = BAUD_DIV-1 and bit index 0.
    - 1: glitch; return to IDLE and push nothing.
  - DATA: at each cnt = 0, shift rx_s into the data byte, LSB first, and reload cnt. After bit 7, go to STOP with cnt = BAUD_DIV-1.
  - STOP: at cnt = 0 sample rx_s, then go to IDLE in the same cycle. No wait for the full stop bit, so back-to-back frames are received.
    - rx_s = 1: push the byte. If the FIFO is full after this cycle's pop, set overrun and drop the byte.
    - rx_s = 0: set frame_err and drop the byte.
- FIFO:
  - Pop happens before push within a cycle, so full + pop + push in the same cycle is accepted and count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - count is 0..FIFO_DEPTH.
- Bus:
  - Every req is granted in the same cycle.
  - Response (rvalid, rdata, err) is registered and appears the next cycle.
  - Side effects (pop, writes, clears) take effect on the grant edge.
- Register map (offset = addr[3:2]):
  - 0x0 RXDATA, read-only.
    - Non-empty: rdata = {24'h0, head byte} and the FIFO pops.
    - Empty: rdata = 32'h8000_0000 and no pop.
    - Writes are ignored with err = 0.
  - 0x4 STATUS.
    - Read: [0] not_empty, [1] full, [2] overrun, [3] frame_err, [15:8] count, other bits 0.
    - Write with be[0] = 1: a 1 in wdata[2] or wdata[3] clears that flag.
    - If a new error event and a clear hit the same cycle, the set wins.
  - 0x8 BAUD_DIV, read/write, bits [DIV_W-1:0].
    - Writes honour be[1:0] per byte.
    - A resulting value below 4 is stored as 4.
    - A new value affects the next cnt reload only; the bit in flight keeps its current count.
  - 0xC: unmapped. Reads and writes give err = 1 and rdata = 0, with no side effects.
- irq = not_empty, registered from FIFO state.

Test Plan:
1. Reset, read STATUS -> rdata = 0, err = 0; read BAUD_DIV -> 16; read RXDATA -> 32'h8000_0000.
2. DIV = 16, drive frame 0x55 (falling edge at cycle 0) -> STATUS not_empty = 1 and count = 1 within 160 cycles, irq = 1. Read RXDATA -> 32'h0000_0055, then irq = 0.
3. 9 back-to-back frames 0x00..0x08 with no reads -> full = 1, count = 8, overrun = 1. Eight RXDATA reads return 0x00..0x07 in order; the 9th read returns 32'h8000_0000. Write 0x4 to STATUS -> overrun = 0.
4. Frame with stop bit 0 (data 0xA5) -> frame_err = 1, count = 0. Start pulse low for 4 cycles only -> nothing pushed, FSM back in IDLE.
5. Write BAUD_DIV = 2 -> reads back 4. Write 0x0000_0008 -> frame 0xC3 at 8 clocks/bit received correctly. Access to offset 0xC -> err = 1 one cycle after req.
6. Assert resetn = 0 for one cycle mid-frame with FIFO count = 3 -> next cycle count = 0, flags = 0, BAUD_DIV = 16; a following clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_sim.sv
// uart_rx_sim: 8N1 serial receiver feeding a receive FIFO, read by the core over the req/gnt/rvalid slave bus.
module uart_rx_sim #(
   parameter int FIFO_DEPTH  = 8,
   parameter int DEFAULT_DIV = 16,
   parameter int DIV_W       = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        rx_i,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        gnt,
   output logic        rvalid,
   output logic        err,
   output logic        irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
   localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(4);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state_q, state_d;
   logic s1_q, s2_q;
   logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_w;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0] count_q, count_d, cnt_pop;
   logic overrun_q, overrun_d, ferr_q, ferr_d;
   logic rvalid_q, err_q, irq_q, irq_d;
   logic [31:0] rdata_q, rdata_d, status;
   logic [1:0] off;
   logic rd, wr, pop, push, ovr_set, ferr_set, clr;
   logic unused;
   assign unused = ^{addr[31:4], addr[1:0], be[3:2], wdata[31:DIV_W]};
   assign gnt = req;
   assign rdata = rdata_q;
   assign rvalid = rvalid_q;
   assign err = err_q;
   assign irq = irq_q;
   always_comb begin
      off = addr[3:2];
      rd = req & ~we;
      wr = req & we;
      pop = rd && off == 2'd0 && count_q != '0;
      cnt_pop = count_q - (AW+1)'(pop);
      state_d = state_q;
      cnt_d = cnt_q;
      bit_d = bit_q;
      shift_d = shift_q;
      push = 1'b0;
      ovr_set = 1'b0;
      ferr_set = 1'b0;
      case (state_q)
         IDLE: if (!s2_q) begin
            state_d = START;
            cnt_d = (div_q >> 1) - ONE;
         end
         START: if (cnt_q != '0) cnt_d = cnt_q - ONE;
         else if (s2_q) state_d = IDLE;
         else begin
            state_d = DATA;
            cnt_d = div_q - ONE;
            bit_d = 3'd0;
         end
         DATA: if (cnt_q != '0) cnt_d = cnt_q - ONE;
         else begin
            shift_d = {s2_q, shift_q[7:1]};
            cnt_d = div_q - ONE;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
         end
         default: if (cnt_q != '0) cnt_d = cnt_q - ONE;
         else begin
            // stop bit is sampled mid-bit so the next start edge is never missed
            state_d = IDLE;
            ferr_set = ~s2_q;
            ovr_set = s2_q && cnt_pop == FULL_CNT;
            push = s2_q && cnt_pop != FULL_CNT;
         end
      endcase
      count_d = cnt_pop + (AW+1)'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
      clr = wr && off == 2'd1 && be[0];
      overrun_d = (overrun_q & ~(clr & wdata[2])) | ovr_set;
      ferr_d = (ferr_q & ~(clr & wdata[3])) | ferr_set;
      div_w = div_q;
      if (be[0]) div_w[7:0] = wdata[7:0];
      if (be[1]) div_w[DIV_W-1:8] = wdata[DIV_W-1:8];
      div_d = (wr && off == 2'd2) ? ((div_w < MIN_DIV) ? MIN_DIV : div_w) : div_q;
      status = {16'h0, 8'(count_q), 4'h0, ferr_q, overrun_q, count_q == FULL_CNT, count_q != '0};
      rdata_d = !rd ? 32'h0 :
                off == 2'd0 ? (count_q != '0 ? {24'h0, mem_q[rd_ptr_q]} : 32'h8000_0000) :
                off == 2'd1 ? status :
                off == 2'd2 ? 32'(div_q) : 32'h0;
      irq_d = count_d != '0;
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         state_q <= IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         shift_q <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q <= '0;
         overrun_q <= 1'b0;
         ferr_q <= 1'b0;
         div_q <= DIV_W'(DEFAULT_DIV);
         rvalid_q <= 1'b0;
         err_q <= 1'b0;
         rdata_q <= '0;
         irq_q <= 1'b0;
      end else begin
         s1_q <= rx_i;
         s2_q <= s1_q;
         state_q <= state_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         shift_q <= shift_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q <= count_d;
         overrun_q <= overrun_d;
         ferr_q <= ferr_d;
         div_q <= div_d;
         rvalid_q <= req;
         err_q <= req && off == 2'd3;
         rdata_q <= rdata_d;
         irq_q <= irq_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= shift_q;
   end
endmodule

// File: tb/tb_uart_rx_sim.sv
// tb_uart_rx_sim: directed tests of the UART receiver, FIFO and register map.
module tb_uart_rx_sim;
   logic clk = 1'b0, resetn = 1'b0, rx_i = 1'b1, req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic [3:0] be = '0;
   logic gnt, rvalid, err, irq;
   logic [31:0] r;
   logic e, v;
   int checks = 0, failures = 0;

   uart_rx_sim dut (.clk(clk), .resetn(resetn), .rx_i(rx_i), .req(req), .addr(addr), .we(we),
                    .be(be), .wdata(wdata), .rdata(rdata), .gnt(gnt), .rvalid(rvalid),
                    .err(err), .irq(irq));

   always #5 clk = ~clk;

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                      output logic [31:0] ro, output logic eo, output logic vo);
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      wait_clk(1);
      req = 1'b0; we = 1'b0;
      ro = rdata; eo = err; vo = rvalid;
   endtask

   task automatic send(input logic [7:0] d, input logic stop_b, input int div);
      rx_i = 1'b0;
      wait_clk(div);
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         wait_clk(div);
      end
      rx_i = stop_b;
      wait_clk(div);
      rx_i = 1'b1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      wait_clk(3);
      checks++; if (rvalid !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL reset_outs rvalid=%b irq=%b exp 0 0", rvalid, irq); end
      checks++; if (rdata !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL reset_rdata got %h err=%b exp 0", rdata, err); end
      resetn = 1'b1;
      wait_clk(1);
      req = 1'b1; addr = 32'h4; #1;
      checks++; if (gnt !== 1'b1) begin failures++; $display("FAIL gnt got %b exp 1", gnt); end
      wait_clk(1);
      req = 1'b0;
      checks++; if (rvalid !== 1'b1 || rdata !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL reset_status v=%b got %h err=%b exp 1 0 0", rvalid, rdata, err); end
      wait_clk(1);
      checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL rvalid_pulse v=%b rdata=%h exp 0 0", rvalid, rdata); end
      bus(0, 32'h8, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'd16) begin failures++; $display("FAIL reset_div got %h exp 10", r); end
      bus(0, 32'h0, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h8000_0000 || v !== 1'b1) begin failures++; $display("FAIL empty_rx got %h v=%b exp 80000000 1", r, v); end
   endtask

   task automatic test_single;
      send(8'h55, 1'b1, 16);
      for (int i = 0; i < 50 && irq !== 1'b1; i++) wait_clk(1);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL single_irq got %b exp 1", irq); end
      bus(0, 32'h4, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0000_0101) begin failures++; $display("FAIL single_status got %h exp 00000101", r); end
      bus(0, 32'h0, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0000_0055) begin failures++; $display("FAIL single_data got %h exp 00000055", r); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_clr got %b exp 0", irq); end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 9; i++) send(8'(i), 1'b1, 16);
      wait_clk(10);
      bus(0, 32'h4, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0000_0807) begin failures++; $display("FAIL full_status got %h exp 00000807", r); end
      for (int i = 0; i < 8; i++) begin
         bus(0, 32'h0, 4'hf, 0, r, e, v);
         checks++; if (r !== 32'(i)) begin failures++; $display("FAIL fifo_order[%0d] got %h exp %h", i, r, 32'(i)); end
      end
      bus(0, 32'h0, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h8000_0000) begin failures++; $display("FAIL fifo_drained got %h exp 80000000", r); end
      bus(1, 32'h4, 4'h1, 32'h4, r, e, v);
      bus(0, 32'h4, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL ovr_clear got %h exp 0", r); end
   endtask

   task automatic test_errors;
      send(8'hA5, 1'b0, 16);
      wait_clk(40);
      bus(0, 32'h4, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0000_0008) begin failures++; $display("FAIL frame_err got %h exp 00000008", r); end
      rx_i = 1'b0;
      wait_clk(4);
      rx_i = 1'b1;
      wait_clk(40);
      bus(0, 32'h4, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0000_0008) begin failures++; $display("FAIL glitch got %h exp 00000008", r); end
      bus(1, 32'h4, 4'h1, 32'h8, r, e, v);
      bus(0, 32'h4, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL ferr_clear got %h exp 0", r); end
   endtask

   task automatic test_baud;
      bus(1, 32'h8, 4'h3, 32'h2, r, e, v);
      bus(0, 32'h8, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h4) begin failures++; $display("FAIL div_min got %h exp 4", r); end
      bus(1, 32'h8, 4'h2, 32'h0000_0108, r, e, v);
      bus(0, 32'h8, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0104) begin failures++; $display("FAIL div_be got %h exp 104", r); end
      bus(1, 32'h8, 4'h3, 32'h8, r, e, v);
      bus(0, 32'h8, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h8) begin failures++; $display("FAIL div_set got %h exp 8", r); end
      send(8'hC3, 1'b1, 8);
      wait_clk(10);
      bus(1, 32'h0, 4'hf, 32'hff, r, e, v);
      checks++; if (e !== 1'b0 || irq !== 1'b1) begin failures++; $display("FAIL rx_write err=%b irq=%b exp 0 1", e, irq); end
      bus(0, 32'h0, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0000_00C3) begin failures++; $display("FAIL div8_data got %h exp 000000c3", r); end
      bus(0, 32'hC, 4'hf, 0, r, e, v);
      checks++; if (e !== 1'b1 || v !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL unmapped_rd err=%b v=%b rdata=%h exp 1 1 0", e, v, r); end
      bus(1, 32'hC, 4'hf, 32'h1234, r, e, v);
      checks++; if (e !== 1'b1) begin failures++; $display("FAIL unmapped_wr err=%b exp 1", e); end
   endtask

   task automatic test_mid_reset;
      send(8'h00, 1'b0, 8);
      wait_clk(20);
      send(8'h11, 1'b1, 8);
      send(8'h22, 1'b1, 8);
      send(8'h33, 1'b1, 8);
      wait_clk(10);
      bus(0, 32'h4, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0000_0309) begin failures++; $display("FAIL pre_reset got %h exp 00000309", r); end
      rx_i = 1'b0;
      wait_clk(30);
      resetn = 1'b0; rx_i = 1'b1;
      wait_clk(1);
      resetn = 1'b1;
      checks++; if (irq !== 1'b0 || rvalid !== 1'b0) begin failures++; $display("FAIL mid_reset irq=%b v=%b exp 0 0", irq, rvalid); end
      bus(0, 32'h4, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL post_reset_status got %h exp 0", r); end
      bus(0, 32'h8, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'd16) begin failures++; $display("FAIL post_reset_div got %h exp 10", r); end
      send(8'h7E, 1'b1, 16);
      wait_clk(10);
      bus(0, 32'h0, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0000_007E) begin failures++; $display("FAIL post_reset_data got %h exp 0000007e", r); end
      bus(0, 32'h4, 4'hf, 0, r, e, v);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL final_status got %h exp 0", r); end
   endtask

   initial begin
      #1;
      test_reset;
      test_single;
      test_back_to_back;
      test_errors;
      test_baud;
      test_mid_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
